mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the E stage of the five-stage pipeline.
- Owns the HI/LO registers, accepts one md operation at a time, and models fixed MULT/DIV latencies with a countdown.
- Raises stall_md to the hazard unit so that D-stage md instructions (mult/div/mfhi/mflo/mthi/mtlo) freeze via pc_en/D_en/E_clr while the unit is occupied.

Parameters:
- MULT_LAT, 5, busy cycles for MULT/MULTU (and MADD family); legal range 1..15.
- DIV_LAT, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 resets the block immediately
- start  in  1  valid md operation in E this cycle
- op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 NONE
- rs_val  in  32  forwarded GPR[rs] in E
- rt_val  in  32  forwarded GPR[rt] in E
- md_D  in  1  instruction in D uses the md unit
- cancel  in  1  abort the in-flight operation (exception flush)
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight
- stall_md  out  1  request to freeze F/D and bubble E

Behaviour:
- Reset (reset=0, asynchronous):
  - hi=0, lo=0, busy=0, state IDLE, cnt=0.
  - Applies mid-operation: the result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, cnt counts down.
- Operation starts (IDLE, start=1):
  - MULT/MULTU/MADD family: latch the 64-bit result computed from rs_val/rt_val at the accepting edge (signed for MULT/MADD/MSUB, unsigned for the U forms). cnt=MULT_LAT, go to RUN.
  - DIV/DIVU: latch quotient -> lo_pending and remainder -> hi_pending. Signed DIV truncates toward zero; the remainder takes the dividend's sign. cnt=DIV_LAT, go to RUN.
  - DIV/DIVU with rt_val=0: still enter RUN for DIV_LAT cycles, but HI/LO are left unchanged at completion.
- Single-cycle and ignored ops (IDLE, start=1):
  - MTHI: hi<=rs_val at this edge, no RUN.
  - MTLO: lo<=rs_val at this edge, no RUN.
  - NONE: ignored.
- RUN:
  - Each edge: cnt<=cnt-1.
  - On the edge where cnt==1: write {hi,lo} (MADD/MADDU: {hi,lo}+product; MSUB/MSUBU: {hi,lo}-product, 64-bit wraparound), go to IDLE.
  - busy is therefore high for exactly LAT cycles after the accepting edge; new HI/LO are visible the cycle busy falls.
- Start while busy: start=1 in RUN is ignored. The hazard unit guarantees this cannot happen via stall_md.
- cancel:
  - In RUN: go to IDLE at the next edge, no HI/LO write, busy=0.
  - In IDLE: suppresses acceptance of a simultaneous start, including MTHI/MTLO.
  - cancel has priority over completion in the same cycle.
- stall_md is combinational: md_D & (busy | (start & op in {1,2,3,4,7..10})).
  - MTHI/MTLO in E do not stall D, because the write lands at this edge and mfhi/mflo in D read it via the E->D forward owned by the hazard unit.
- Outputs hi and lo are registers; no combinational path from the inputs to hi/lo.

Optional Feature:
- MDU_MADD_EN
- Defined: ops 7-10 (MADD, MADDU, MSUB, MSUBU) are implemented as above and cause stall_md.
- Undefined: ops 7-10 decode as NONE. No accumulate adder is synthesized, no state change, no stall contribution.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFF rt=2 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV rs=-7 (0xFFFFFFF9) rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with rt=0 -> 10 busy cycles, HI/LO unchanged.
- MULTU 3x4 with md_D=1 held -> stall_md=1 in the start cycle and all 5 busy cycles; 0 the cycle busy falls; lo=12.
- MTHI rs=0x1234 -> hi=0x1234 the next cycle, busy never asserted, stall_md=0 with md_D=1.
- MULT started, cancel pulsed in busy cycle 3 -> busy=0 the next cycle, HI/LO keep their previous values. Reset=0 mid-DIV -> hi=lo=0 immediately.
- With MDU_MADD_EN: hi=0, lo=10, then MADD rs=2 rt=3 -> lo=16 after 5 cycles. Without the macro, the same op leaves lo=10 and busy=0.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer for the E stage.
// Owns HI/LO, accepts one md op at a time, models MULT/DIV latency with a
// countdown and requests a front-end freeze (stall_md) while occupied.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU, ops 7-10).
// Without it those opcodes decode as NONE and no accumulate adder exists.
module mdu_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_D,
    input  logic        cancel,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    // How the pending 64-bit value is applied to {hi,lo} at completion.
    typedef enum logic [1:0] {PM_WR = 2'd0, PM_ADD = 2'd1, PM_SUB = 2'd2, PM_KEEP = 2'd3} pmode_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [63:0] pend;
    pmode_t      pmode;

    logic        is_mul, is_div, is_acc, is_long, mul_signed, accept, done;
    logic [63:0] prod;
    logic        a_neg, b_neg;
    logic [31:0] ua, ub, uq, ur, quo, rem;

    // Opcode decode; the accumulate family only exists when the feature is built.
    always_comb begin
        is_mul     = (op == OP_MULT) || (op == OP_MULTU);
        is_div     = (op == OP_DIV)  || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        is_acc     = (op >= OP_MADD) && (op <= OP_MSUBU);
`else
        is_acc     = 1'b0;
`endif
        is_long    = is_mul || is_div || is_acc;
        mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
        accept     = (state == IDLE) && start && !cancel;
        done       = (state == RUN) && (cnt == 4'd1) && !cancel;
    end

    // 64-bit product: sign- or zero-extend both operands, keep the low 64 bits.
    always_comb begin
        prod = {{32{mul_signed & rs_val[31]}}, rs_val} * {{32{mul_signed & rt_val[31]}}, rt_val};
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. Divide-by-zero result is unused.
    always_comb begin
        a_neg = (op == OP_DIV) && rs_val[31];
        b_neg = (op == OP_DIV) && rt_val[31];
        ua    = a_neg ? 32'd0 - rs_val : rs_val;
        ub    = b_neg ? 32'd0 - rt_val : rt_val;
        uq    = (ub == 32'd0) ? 32'd0 : ua / ub;
        ur    = (ub == 32'd0) ? 32'd0 : ua % ub;
        quo   = (a_neg ^ b_neg) ? 32'd0 - uq : uq;
        rem   = a_neg ? 32'd0 - ur : ur;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: long ops enter RUN; cancel or the final count returns to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept && is_long) state_nx = RUN;
            RUN:  if (cancel || cnt == 4'd1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs: busy mirrors RUN; stall covers the accepting cycle of long ops too.
    always_comb begin
        busy     = (state == RUN);
        stall_md = md_D && (busy || (start && is_long));
    end

    // Countdown and pending-result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= 4'd0;
            pend  <= 64'd0;
            pmode <= PM_WR;
        end else if (accept && is_long) begin
            cnt <= is_div ? 4'(DIV_LAT) : 4'(MULT_LAT);
            if (is_div) begin
                pend  <= {rem, quo};
                pmode <= (rt_val == 32'd0) ? PM_KEEP : PM_WR;
            end else begin
                pend  <= prod;
                pmode <= !is_acc ? PM_WR : (op >= OP_MSUB) ? PM_SUB : PM_ADD;
            end
        end else if (state == RUN) begin
            cnt <= cancel ? 4'd0 : cnt - 4'd1;
        end
    end

    // HI/LO: immediate MTHI/MTLO writes, or the pending result at completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (accept && op == OP_MTHI) begin
            hi <= rs_val;
        end else if (accept && op == OP_MTLO) begin
            lo <= rs_val;
        end else if (done) begin
            case (pmode)
                PM_WR:   {hi, lo} <= pend;
`ifdef MDU_MADD_EN
                PM_ADD:  {hi, lo} <= {hi, lo} + pend;
                PM_SUB:  {hi, lo} <= {hi, lo} - pend;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios plus randomized ops
// checked against a behavioural HI/LO model built from 64-bit arithmetic.
module tb_mdu_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        md_D = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, stall_md;

    int vectors = 0;
    int errors  = 0;

    // Reference architectural state.
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    mdu_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .md_D(md_D), .cancel(cancel),
        .hi(hi), .lo(lo), .busy(busy), .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Architectural effect of one accepted op; returns the expected busy length.
    task automatic model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        logic [63:0] p;
        longint      q, r;
        lat = 0;
        case (o)
            4'd1: begin p = longint'($signed(a)) * longint'($signed(b)); {mhi, mlo} = p; lat = MULT_LAT; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; {mhi, mlo} = p; lat = MULT_LAT; end
            4'd3: begin
                if (b != 0) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    mlo = q[31:0];
                    mhi = r[31:0];
                end
                lat = DIV_LAT;
            end
            4'd4: begin
                if (b != 0) begin mlo = a / b; mhi = a % b; end
                lat = DIV_LAT;
            end
            4'd5: mhi = a;
            4'd6: mlo = a;
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: begin
                if (o == 4'd7 || o == 4'd9) p = longint'($signed(a)) * longint'($signed(b));
                else                        p = {32'd0, a} * {32'd0, b};
                if (o <= 4'd8) {mhi, mlo} = {mhi, mlo} + p;
                else           {mhi, mlo} = {mhi, mlo} - p;
                lat = MULT_LAT;
            end
`endif
            default: lat = 0;
        endcase
    endtask

    // Drive one op, capture stall_md in the start cycle, count busy cycles (bounded).
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic md, output logic stl, output int bc);
        op = o; rs_val = a; rt_val = b; md_D = md; start = 1'b1;
        #1;
        stl = stall_md;
        tick;
        start = 1'b0; op = 4'd0;
        bc = 0;
        while (busy && bc < 40) begin
            bc++;
            tick;
        end
    endtask

    task automatic test_reset;
        #2;
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b, want 0/0/0", hi, lo, busy);
        end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_mult;
        logic s; int bc, lat;
        model_op(4'd1, 32'hFFFFFFFF, 32'd2, lat);
        issue(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, s, bc);
        vectors++;
        if (bc !== 5) begin errors++; $display("FAIL mult_busy: got %0d cycles, want 5", bc); end
        vectors++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
            errors++; $display("FAIL mult_result: hi=%h lo=%h, want ffffffff fffffffe", hi, lo);
        end
    endtask

    task automatic test_div;
        logic s; int bc, lat;
        model_op(4'd3, 32'hFFFFFFF9, 32'd2, lat);
        issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, s, bc);
        vectors++;
        if (bc !== 10) begin errors++; $display("FAIL div_busy: got %0d cycles, want 10", bc); end
        vectors++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL div_signed: hi=%h lo=%h, want ffffffff fffffffd", hi, lo);
        end
        model_op(4'd4, 32'd77, 32'd0, lat);
        issue(4'd4, 32'd77, 32'd0, 1'b0, s, bc);
        vectors++;
        if (bc !== 10 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            errors++; $display("FAIL divu_zero: busy=%0d hi=%h lo=%h, want 10 ffffffff fffffffd", bc, hi, lo);
        end
        model_op(4'd3, 32'h80000000, 32'hFFFFFFFF, lat);
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, s, bc);
        vectors++;
        if (hi !== 32'd0 || lo !== 32'h80000000) begin
            errors++; $display("FAIL div_overflow: hi=%h lo=%h, want 00000000 80000000", hi, lo);
        end
    endtask

    task automatic test_stall;
        int bc, lat;
        model_op(4'd2, 32'd3, 32'd4, lat);
        op = 4'd2; rs_val = 32'd3; rt_val = 32'd4; md_D = 1'b1; start = 1'b1;
        #1;
        vectors++;
        if (stall_md !== 1'b1) begin errors++; $display("FAIL stall_start: got %b want 1", stall_md); end
        tick;
        start = 1'b0; op = 4'd0;
        bc = 0;
        while (busy && bc < 40) begin
            vectors++;
            if (stall_md !== 1'b1) begin errors++; $display("FAIL stall_busy: cycle %0d got %b want 1", bc, stall_md); end
            bc++;
            tick;
        end
        vectors++;
        if (bc !== 5 || stall_md !== 1'b0 || lo !== 32'd12 || hi !== 32'd0) begin
            errors++; $display("FAIL stall_release: busy=%0d stall=%b hi=%h lo=%h, want 5 0 0 12", bc, stall_md, hi, lo);
        end
        md_D = 1'b0;
    endtask

    task automatic test_mthi;
        logic s; int bc, lat;
        model_op(4'd5, 32'h1234, 32'd0, lat);
        issue(4'd5, 32'h1234, 32'd0, 1'b1, s, bc);
        vectors++;
        if (hi !== 32'h1234 || bc !== 0 || s !== 1'b0) begin
            errors++; $display("FAIL mthi: hi=%h busy=%0d stall=%b, want 1234 0 0", hi, bc, s);
        end
        md_D = 1'b0;
    endtask

    task automatic test_cancel;
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        op = 4'd1; rs_val = 32'd1000; rt_val = 32'd1000; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        cancel = 1'b1;
        tick;
        cancel = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b want 0", busy); end
        repeat (4) tick;
        vectors++;
        if (hi !== h0 || lo !== l0) begin
            errors++; $display("FAIL cancel_keep: hi=%h lo=%h, want %h %h", hi, lo, h0, l0);
        end
        // cancel while idle blocks a simultaneous MTLO
        op = 4'd6; rs_val = 32'hABCD; start = 1'b1; cancel = 1'b1;
        tick;
        start = 1'b0; cancel = 1'b0;
        vectors++;
        if (lo !== l0 || busy !== 1'b0) begin
            errors++; $display("FAIL cancel_idle: lo=%h busy=%b, want %h 0", lo, busy, l0);
        end
    endtask

    task automatic test_reset_mid;
        logic s; int bc, lat;
        model_op(4'd5, 32'hDEAD, 32'd0, lat);
        issue(4'd5, 32'hDEAD, 32'd0, 1'b0, s, bc);
        op = 4'd3; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        reset = 1'b0;
        #1;
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid: hi=%h lo=%h busy=%b, want 0 0 0", hi, lo, busy);
        end
        #2;
        reset = 1'b1;
        mhi = 32'd0; mlo = 32'd0;
        repeat (12) tick;
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_discard: hi=%h lo=%h busy=%b, want 0 0 0", hi, lo, busy);
        end
    endtask

    task automatic test_madd;
        logic s; int bc, lat;
        model_op(4'd5, 32'd0, 32'd0, lat);
        issue(4'd5, 32'd0, 32'd0, 1'b0, s, bc);
        model_op(4'd6, 32'd10, 32'd0, lat);
        issue(4'd6, 32'd10, 32'd0, 1'b0, s, bc);
        model_op(4'd7, 32'd2, 32'd3, lat);
        issue(4'd7, 32'd2, 32'd3, 1'b1, s, bc);
        md_D = 1'b0;
`ifdef MDU_MADD_EN
        vectors++;
        if (bc !== 5 || s !== 1'b1 || lo !== 32'd16 || hi !== 32'd0) begin
            errors++; $display("FAIL madd: busy=%0d stall=%b hi=%h lo=%h, want 5 1 0 16", bc, s, hi, lo);
        end
`else
        vectors++;
        if (bc !== 0 || s !== 1'b0 || lo !== 32'd10 || hi !== 32'd0) begin
            errors++; $display("FAIL madd_off: busy=%0d stall=%b hi=%h lo=%h, want 0 0 0 10", bc, s, hi, lo);
        end
`endif
    endtask

    task automatic test_random;
        logic [3:0]  o;
        logic [31:0] a, b;
        logic        md, s;
        int          bc, lat;
        for (int i = 0; i < 80; i++) begin
            o  = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 2) == 0) ? $urandom | 32'h80000000 : $urandom;
            md = 1'($urandom_range(0, 1));
            model_op(o, a, b, lat);
            issue(o, a, b, md, s, bc);
            md_D = 1'b0;
            vectors++;
            if (bc !== lat || s !== (md && lat > 0)) begin
                errors++; $display("FAIL rand_timing op=%0d: busy=%0d stall=%b, want %0d %b", o, bc, s, lat, md && lat > 0);
            end
            vectors++;
            if (hi !== mhi || lo !== mlo) begin
                errors++; $display("FAIL rand_result op=%0d a=%h b=%h: hi=%h lo=%h, want %h %h", o, a, b, hi, lo, mhi, mlo);
            end
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_stall;
        test_mthi;
        test_cancel;
        test_reset_mid;
        test_madd;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
